// File: rtl/data_queue.sv
// Circular-buffer word queue between the number generators and the display stage.
// Enqueues on a write strobe; dequeues one word per rising edge of the slow clock level.
module data_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WIDTH-1:0]         data_in_i,
  input  logic                     enq_i,
  input  logic                     clk_slow_i,
  output logic [WIDTH-1:0]         data_2_o,
  output logic [$clog2(DEPTH):0]   len_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] data_2_q, data_2_d;
  logic             ovf_q, ovf_d;
  logic             clk_slow_q;
  logic             deq_tick;
  logic             wr_en, rd_en;
  logic             full, empty;

  assign full     = (len_q == LW'(DEPTH));
  assign empty    = (len_q == '0);
  assign deq_tick = clk_slow_i & ~clk_slow_q;
  // A tick on a full queue frees a slot on the same edge, so the write may proceed.
  assign wr_en    = enq_i & (~full | deq_tick);
  assign rd_en    = deq_tick & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    data_2_d = data_2_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      data_2_d = mem_q[rd_ptr_q];
    end
    unique case ({wr_en, rd_en})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase
    if (enq_i && !wr_en) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      data_2_q   <= '0;
      ovf_q      <= 1'b0;
      clk_slow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      data_2_q   <= data_2_d;
      ovf_q      <= ovf_d;
      clk_slow_q <= clk_slow_i;
    end
  end

  // Storage is not reset; the pointers and len define which entries are live.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  assign data_2_o = data_2_q;
  assign len_o    = len_q;
  assign full_o   = full;
  assign empty_o  = empty;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_data_queue.sv
// Scoreboard bench for data_queue: stimulus queues expected dequeued words,
// a monitor pops and compares each time data_2 changes outside reset.
module tb_data_queue;

  logic        clk_i      = 1'b0;
  logic        rst_ni     = 1'b0;
  logic [15:0] data_in_i  = '0;
  logic        enq_i      = 1'b0;
  logic        clk_slow_i = 1'b0;
  logic [15:0] data_2_o;
  logic [3:0]  len_o;
  logic        full_o, empty_o, ovf_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  data_queue #(.DEPTH(8), .WIDTH(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_in_i  (data_in_i),
    .enq_i      (enq_i),
    .clk_slow_i (clk_slow_i),
    .data_2_o   (data_2_o),
    .len_o      (len_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: any change of data_2 outside reset is one dequeue.
  logic [15:0] prev = '0;
  always @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev = '0;
    end else if (data_2_o !== prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_deq: got 0x%0h expected no change from 0x%0h", data_2_o, prev);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_2_o !== e) begin
          bad++;
          $display("FAIL deq_data: got 0x%0h expected 0x%0h", data_2_o, e);
        end
      end
      prev = data_2_o;
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    enq_i = 1'b1; data_in_i = v; clk_slow_i = 1'b0;
    cyc();
    enq_i = 1'b0;
  endtask

  task automatic tick(input bit exp_deq, input logic [15:0] v);
    if (exp_deq) exp_q.push_back(v);
    clk_slow_i = 1'b1;
    cyc();
    clk_slow_i = 1'b0;
    cyc();
  endtask

  // Enqueue and tick on the same edge.
  task automatic both(input logic [15:0] v, input bit exp_deq, input logic [15:0] e);
    if (exp_deq) exp_q.push_back(e);
    enq_i = 1'b1; data_in_i = v; clk_slow_i = 1'b1;
    cyc();
    enq_i = 1'b0; clk_slow_i = 1'b0;
    cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data_2"}, 32'(data_2_o), 32'h0);
    chk({tag, "_len"},    32'(len_o),    32'd0);
    chk({tag, "_empty"},  32'(empty_o),  32'd1);
    chk({tag, "_full"},   32'(full_o),   32'd0);
    chk({tag, "_ovf"},    32'(ovf_o),    32'd0);
  endtask

  initial begin
    #1;
    chk_reset_vals("rst0");
    repeat (2) cyc();
    #1 rst_ni = 1'b1;
    cyc();

    // Simultaneous write and tick on empty: write only, no bypass.
    both(16'h5555, 1'b0, 16'h0);
    chk("empty_both_data_2", 32'(data_2_o), 32'h0);
    chk("empty_both_len",    32'(len_o),    32'd1);
    tick(1'b1, 16'h5555);
    chk("after_5555_len", 32'(len_o), 32'd0);

    // Basic in-order dequeue.
    push(16'h0001); push(16'h0002); push(16'h0003);
    chk("three_len", 32'(len_o), 32'd3);
    tick(1'b1, 16'h0001);
    chk("three_len_a", 32'(len_o), 32'd2);
    tick(1'b1, 16'h0002);
    tick(1'b1, 16'h0003);
    chk("three_len_end", 32'(len_o),   32'd0);
    chk("three_empty",   32'(empty_o), 32'd1);

    // Full queue with simultaneous write and read.
    for (int i = 0; i < 8; i++) push(16'h00B0 + 16'(i));
    chk("b_full", 32'(full_o), 32'd1);
    both(16'h1234, 1'b1, 16'h00B0);
    chk("full_both_len", 32'(len_o),  32'd8);
    chk("full_both_full", 32'(full_o), 32'd1);
    chk("full_both_ovf", 32'(ovf_o),  32'd0);
    for (int i = 1; i < 8; i++) tick(1'b1, 16'h00B0 + 16'(i));
    tick(1'b1, 16'h1234);
    chk("b_drained", 32'(empty_o), 32'd1);

    // Tick on empty: nothing changes.
    tick(1'b0, 16'h0);
    chk("empty_tick_data_2", 32'(data_2_o), 32'h1234);
    chk("empty_tick_len",    32'(len_o),    32'd0);

    // Overflow: ninth write dropped, ovf sticky.
    for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i));
    chk("a_ovf_pre", 32'(ovf_o), 32'd0);
    push(16'hFFFF);
    chk("ovf_full", 32'(full_o), 32'd1);
    chk("ovf_len",  32'(len_o),  32'd8);
    chk("ovf_set",  32'(ovf_o),  32'd1);
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h00A0 + 16'(i));
    chk("a_empty",  32'(empty_o), 32'd1);
    chk("ovf_sticky", 32'(ovf_o), 32'd1);

    // Level held high: single dequeue.
    for (int i = 0; i < 4; i++) push(16'h00C0 + 16'(i));
    exp_q.push_back(16'h00C0);
    clk_slow_i = 1'b1;
    repeat (20) cyc();
    chk("held_len", 32'(len_o), 32'd3);
    clk_slow_i = 1'b0;
    cyc();

    // Asynchronous reset pulse mid-cycle with 5 entries.
    push(16'h00D0); push(16'h00D1);
    chk("pre_rst_len", 32'(len_o), 32'd5);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1 chk_reset_vals("arst");
    #1 rst_ni = 1'b1;
    cyc();
    tick(1'b0, 16'h0);
    chk("post_rst_data_2", 32'(data_2_o), 32'h0);
    chk("post_rst_empty",  32'(empty_o),  32'd1);
    push(16'h00E0);
    chk("post_rst_enq_len", 32'(len_o), 32'd1);
    tick(1'b1, 16'h00E0);

    repeat (3) cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_queue.md
DATA_QUEUE -- requirements
Module: data_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of 16-bit entries held; a power of two, 2..16.
REQ-002 Parameter WIDTH, default 16, bits per entry; equals the data_2 width consumed by the display stage.
REQ-003 clk  input  1  system clock, 100 MHz; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; the block is in reset while rst = 0.
REQ-005 data_in  input  WIDTH  word produced by the Fibonacci or Timer generator.
REQ-006 enq  input  1  one-cycle write strobe; data_in is valid when enq = 1.
REQ-007 clk_slow  input  1  slow clock level from the prog-selected divider, synchronous to clk; each rising edge requests one dequeue.
REQ-008 data_2  output  WIDTH  registered, most recently dequeued word, driven to the display stage.
REQ-009 len  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 full  output  1  1 when len = DEPTH.
REQ-011 empty  output  1  1 when len = 0.
REQ-012 ovf  output  1  sticky flag, set when a write is dropped because the queue is full.

Function
REQ-013 Storage is a circular buffer of DEPTH entries with a write pointer and a read pointer, each wrapping from DEPTH-1 to 0.
REQ-014 clk_slow is registered once; deq_tick is 1 for exactly one clk cycle when clk_slow = 1 and its registered copy = 0.
REQ-015 A level held high on clk_slow produces no further ticks.
REQ-016 Write accepted: enq = 1 and (full = 0 or deq_tick = 1).
- Stores data_in at the write pointer.
- Advances the write pointer.
REQ-017 Read accepted: deq_tick = 1 and empty = 0.
- data_2 loads the entry at the read pointer on the same edge.
- Advances the read pointer.
REQ-018 len: +1 on a write only, -1 on a read only, unchanged when both or neither occur; full and empty are derived from len in the same cycle.
REQ-019 Simultaneous write and read when full: both accepted; len stays DEPTH; ovf is not set.
REQ-020 Simultaneous write and read when empty: write accepted, read ignored, no bypass; data_2 holds; len becomes 1.
REQ-021 enq = 1 when full with no deq_tick: write dropped, pointers and len unchanged, ovf becomes 1 on that edge.
REQ-022 deq_tick when empty with no enq: no change; data_2 keeps its previous value.
REQ-023 Entries are dequeued in write order, with no loss and no duplication.
REQ-024 ovf stays 1 until reset; no other action clears it.
REQ-025 data_2 changes only on an accepted read or on reset.

Reset
REQ-026 While rst = 0, and immediately on its assertion regardless of clk:
- data_2 = 0, len = 0, empty = 1, full = 0, ovf = 0.
- Both pointers = 0; clk_slow registered copy = 0.
REQ-027 Reset mid-operation discards all stored entries; storage array contents need not be cleared.
REQ-028 On release of rst, the first rising edge of clk_slow at or after release produces a deq_tick; the first enq after release is accepted.

Verification
REQ-029 Reset, enq 0x0001, 0x0002, 0x0003, then three clk_slow rising edges -> data_2 = 0x0001, 0x0002, 0x0003 in turn; len 3->0; empty = 1 at the end.
REQ-030 Write 8 words 0x00A0..0x00A7, then enq 0xFFFF -> full = 1, len = 8, ovf = 1; the next 8 reads return 0x00A0..0x00A7 (0xFFFF never appears).
REQ-031 Full queue, enq 0x1234 on the same cycle as a deq_tick -> data_2 = oldest entry, len = 8, ovf = 0; 0x1234 is dequeued last.
REQ-032 Empty queue, enq 0x5555 on the same cycle as a deq_tick -> data_2 unchanged (0x0000 after reset), len = 1; the next tick gives data_2 = 0x5555.
REQ-033 clk_slow held high 20 cycles with 4 entries stored -> exactly one dequeue, len = 3.
REQ-034 Load 5 entries, pulse rst low for a partial cycle asynchronously -> outputs at reset values immediately; after release, a tick leaves data_2 = 0 and empty = 1.
